// File: rtl/nts_api_initiator.sv
// nts_api_initiator: single-outstanding bus initiator for the 12-bit NTS register API.
// Latency: command accept in cycle N -> cs strobe at N+1, o_rsp_valid at N+2+READ_DELAY.
// Backpressure: o_cmd_ready only in IDLE; the response is held until i_rsp_ready.
// Optional macro NTS_API_INITIATOR_ADDR_CHECK_EN: commands addressed at or above ADDR_TOP
//   are answered with o_rsp_error=1 and never reach the bus.
// Ports: i_clk/i_areset (async, active high); command port i_cmd_*/o_cmd_ready;
//   response port o_rsp_*/i_rsp_ready; API bus o_api_*/i_api_read_data; o_txn_count.
module nts_api_initiator #(
   parameter int unsigned READ_DELAY = 1,
   parameter logic [11:0] ADDR_TOP   = 12'h200
) (
   input  logic        i_clk,
   input  logic        i_areset,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic        i_cmd_we,
   input  logic [11:0] i_cmd_address,
   input  logic [31:0] i_cmd_write_data,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_read_data,
   output logic        o_rsp_error,
   output logic        o_api_cs,
   output logic        o_api_we,
   output logic [11:0] o_api_address,
   output logic [31:0] o_api_write_data,
   input  logic [31:0] i_api_read_data,
   output logic [31:0] o_txn_count
);

`ifdef NTS_API_INITIATOR_ADDR_CHECK_EN
   localparam bit ADDR_CHECK = 1'b1;
`else
   localparam bit ADDR_CHECK = 1'b0;
`endif

   localparam logic [2:0] RD = READ_DELAY[2:0];

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t      state_q,     state_d;
   logic [2:0]  cnt_q,       cnt_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic        api_cs_q,    api_cs_d;
   logic        api_we_q,    api_we_d;
   logic [11:0] api_addr_q,  api_addr_d;
   logic [31:0] api_wdata_q, api_wdata_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_data_q,  rsp_data_d;
   logic        rsp_error_q, rsp_error_d;
   logic [31:0] txn_count_q, txn_count_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      api_we_d    = api_we_q;
      api_addr_d  = api_addr_q;
      api_wdata_d = api_wdata_q;
      rsp_data_d  = rsp_data_q;
      rsp_error_d = rsp_error_q;
      txn_count_d = txn_count_q;

      case (state_q)
         S_IDLE: begin
            // cmd_ready_q gates acceptance so nothing is taken in the first cycle after reset
            if (cmd_ready_q && i_cmd_valid) begin
               if (ADDR_CHECK && (i_cmd_address >= ADDR_TOP)) begin
                  state_d     = S_RESP;
                  rsp_error_d = 1'b1;
                  rsp_data_d  = 32'h0;
               end else begin
                  // the API output registers double as the command latch
                  state_d     = S_ISSUE;
                  api_we_d    = i_cmd_we;
                  api_addr_d  = i_cmd_address;
                  api_wdata_d = i_cmd_write_data;
               end
            end
         end
         S_ISSUE: begin
            if (RD == 3'd0) begin
               state_d    = S_RESP;
               rsp_data_d = api_we_q ? 32'h0 : i_api_read_data;
            end else begin
               state_d = S_WAIT;
               cnt_d   = 3'd1;
            end
         end
         S_WAIT: begin
            if (cnt_q == RD) begin
               state_d    = S_RESP;
               rsp_data_d = api_we_q ? 32'h0 : i_api_read_data;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_RESP: begin
            if (i_rsp_ready) begin
               state_d     = S_IDLE;
               txn_count_d = txn_count_q + 32'd1;
               rsp_data_d  = 32'h0;
               rsp_error_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // bus fields carry the command only while a bus cycle is in flight
      if ((state_d == S_IDLE) || (state_d == S_RESP)) begin
         api_we_d    = 1'b0;
         api_addr_d  = 12'h0;
         api_wdata_d = 32'h0;
      end

      cmd_ready_d = (state_d == S_IDLE);
      api_cs_d    = (state_d == S_ISSUE);
      rsp_valid_d = (state_d == S_RESP);
   end

   always_ff @(posedge i_clk or posedge i_areset) begin
      if (i_areset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 3'd0;
         cmd_ready_q <= 1'b0;
         api_cs_q    <= 1'b0;
         api_we_q    <= 1'b0;
         api_addr_q  <= 12'h0;
         api_wdata_q <= 32'h0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 32'h0;
         rsp_error_q <= 1'b0;
         txn_count_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_ready_q <= cmd_ready_d;
         api_cs_q    <= api_cs_d;
         api_we_q    <= api_we_d;
         api_addr_q  <= api_addr_d;
         api_wdata_q <= api_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_error_q <= rsp_error_d;
         txn_count_q <= txn_count_d;
      end
   end

   assign o_cmd_ready      = cmd_ready_q;
   assign o_api_cs         = api_cs_q;
   assign o_api_we         = api_we_q;
   assign o_api_address    = api_addr_q;
   assign o_api_write_data = api_wdata_q;
   assign o_rsp_valid      = rsp_valid_q;
   assign o_rsp_read_data  = rsp_data_q;
   assign o_rsp_error      = rsp_error_q;
   assign o_txn_count      = txn_count_q;

endmodule

// File: tb/tb_nts_api_initiator.sv
// tb_nts_api_initiator: directed bench for nts_api_initiator with READ_DELAY=1.
// Inputs change and outputs are sampled on the falling clock edge.
// API model: read data equals 32'hCAFE_0000 | (address >> 4), valid the cycle after cs.
module tb_nts_api_initiator;

   logic        clk;
   logic        i_areset;
   logic        i_cmd_valid;
   logic        o_cmd_ready;
   logic        i_cmd_we;
   logic [11:0] i_cmd_address;
   logic [31:0] i_cmd_write_data;
   logic        o_rsp_valid;
   logic        i_rsp_ready;
   logic [31:0] o_rsp_read_data;
   logic        o_rsp_error;
   logic        o_api_cs;
   logic        o_api_we;
   logic [11:0] o_api_address;
   logic [31:0] o_api_write_data;
   logic [31:0] api_rdata;
   logic [31:0] o_txn_count;

   nts_api_initiator #(.READ_DELAY(1), .ADDR_TOP(12'h200)) dut (
      .i_clk            (clk),
      .i_areset         (i_areset),
      .i_cmd_valid      (i_cmd_valid),
      .o_cmd_ready      (o_cmd_ready),
      .i_cmd_we         (i_cmd_we),
      .i_cmd_address    (i_cmd_address),
      .i_cmd_write_data (i_cmd_write_data),
      .o_rsp_valid      (o_rsp_valid),
      .i_rsp_ready      (i_rsp_ready),
      .o_rsp_read_data  (o_rsp_read_data),
      .o_rsp_error      (o_rsp_error),
      .o_api_cs         (o_api_cs),
      .o_api_we         (o_api_we),
      .o_api_address    (o_api_address),
      .o_api_write_data (o_api_write_data),
      .i_api_read_data  (api_rdata),
      .o_txn_count      (o_txn_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // API slave model and cs monitor
   logic        rd_pend = 1'b0;
   logic [11:0] rd_addr = 12'h0;
   int          cs_cnt  = 0;
   int          cs_cyc  = 0;
   logic        cs_we;
   logic [11:0] cs_addr;
   logic [31:0] cs_data;
   initial api_rdata = 32'h0BAD_0BAD;
   always @(negedge clk) begin
      api_rdata = rd_pend ? (32'hCAFE_0000 | {24'h0, rd_addr[11:4]}) : 32'h0BAD_0BAD;
      rd_pend   = o_api_cs && !o_api_we;
      rd_addr   = o_api_address;
      if (o_api_cs) begin
         cs_cnt++;
         cs_cyc  = cyc;
         cs_we   = o_api_we;
         cs_addr = o_api_address;
         cs_data = o_api_write_data;
      end
   end

   // Present a command; n = cycle in which it is accepted. Returns at the next falling edge.
   task automatic send(input logic we, input logic [11:0] a, input logic [31:0] d, output int n);
      int t;
      i_cmd_valid = 1'b1; i_cmd_we = we; i_cmd_address = a; i_cmd_write_data = d;
      t = 0;
      while (!o_cmd_ready && t < 50) begin @(negedge clk); t++; end
      if (!o_cmd_ready) check("accept_timeout", 32'd0, 32'd1);
      n = cyc;
      @(negedge clk);
      i_cmd_valid = 1'b0; i_cmd_we = 1'b0; i_cmd_address = 12'h0; i_cmd_write_data = 32'h0;
   endtask

   task automatic wait_rsp(output int rc);
      int t;
      t = 0;
      while (!o_rsp_valid && t < 50) begin @(negedge clk); t++; end
      if (!o_rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
      rc = cyc;
   endtask

   task automatic take_rsp();
      i_rsp_ready = 1'b1;
      @(negedge clk);
      i_rsp_ready = 1'b0;
   endtask

   initial begin
      int n, rc, cs0;
      logic stable;
      i_areset = 1'b1; i_cmd_valid = 1'b0; i_cmd_we = 1'b0; i_cmd_address = 12'h0;
      i_cmd_write_data = 32'h0; i_rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", {31'h0, o_cmd_ready}, 32'd0);
      check("rst_rsp_valid", {31'h0, o_rsp_valid}, 32'd0);
      check("rst_cs",        {31'h0, o_api_cs},    32'd0);
      check("rst_txn",       o_txn_count,          32'd0);
      i_areset = 1'b0;
      @(negedge clk);
      check("rel_cmd_ready", {31'h0, o_cmd_ready}, 32'd1);

      // read 0x010
      cs0 = cs_cnt;
      send(1'b0, 12'h010, 32'h0, n);
      wait_rsp(rc);
      check("rd_cs_count",  cs_cnt - cs0,        32'd1);
      check("rd_cs_cycle",  cs_cyc,              n + 1);
      check("rd_cs_we",     {31'h0, cs_we},      32'd0);
      check("rd_cs_addr",   {20'h0, cs_addr},    32'h010);
      check("rd_rsp_cycle", rc,                  n + 3);
      check("rd_data",      o_rsp_read_data,     32'hCAFE_0001);
      check("rd_error",     {31'h0, o_rsp_error}, 32'd0);
      check("rd_resp_addr", {20'h0, o_api_address}, 32'h0);
      check("rd_ready_lo",  {31'h0, o_cmd_ready}, 32'd0);
      take_rsp();
      check("rd_valid_drop", {31'h0, o_rsp_valid}, 32'd0);
      check("rd_txn",        o_txn_count,          32'd1);
      check("rd_ready_hi",   {31'h0, o_cmd_ready}, 32'd1);

      // write 0x085
      cs0 = cs_cnt;
      send(1'b1, 12'h085, 32'hDEAD_BEEF, n);
      wait_rsp(rc);
      check("wr_cs_count", cs_cnt - cs0,          32'd1);
      check("wr_cs_we",    {31'h0, cs_we},        32'd1);
      check("wr_cs_addr",  {20'h0, cs_addr},      32'h085);
      check("wr_cs_data",  cs_data,               32'hDEAD_BEEF);
      check("wr_rsp_cyc",  rc,                    n + 3);
      check("wr_data",     o_rsp_read_data,       32'h0);
      check("wr_error",    {31'h0, o_rsp_error},  32'd0);
      take_rsp();
      check("wr_txn",      o_txn_count,           32'd2);

      // back-pressure with a second command waiting
      send(1'b0, 12'h020, 32'h0, n);
      wait_rsp(rc);
      cs0 = cs_cnt;
      check("bp_data", o_rsp_read_data, 32'hCAFE_0002);
      i_cmd_valid = 1'b1; i_cmd_we = 1'b1; i_cmd_address = 12'h030; i_cmd_write_data = 32'h1234_5678;
      stable = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (!o_rsp_valid || o_rsp_read_data !== 32'hCAFE_0002 || o_cmd_ready) stable = 1'b0;
      end
      check("bp_stable",   {31'h0, stable},  32'd1);
      check("bp_no_cs",    cs_cnt - cs0,     32'd0);
      check("bp_txn_hold", o_txn_count,      32'd2);
      take_rsp();
      i_cmd_valid = 1'b0;
      check("bp_txn",      o_txn_count,      32'd3);
      repeat (3) @(negedge clk);
      check("bp_not_taken", cs_cnt - cs0,    32'd0);

      // i_rsp_ready with no response pending
      i_rsp_ready = 1'b1;
      repeat (4) @(negedge clk);
      i_rsp_ready = 1'b0;
      check("idle_rdy_txn", o_txn_count, 32'd3);

      // first unmapped address
      cs0 = cs_cnt;
      send(1'b0, 12'h200, 32'h0, n);
      wait_rsp(rc);
`ifdef NTS_API_INITIATOR_ADDR_CHECK_EN
      check("oob_cs",    cs_cnt - cs0,         32'd0);
      check("oob_cyc",   rc,                   n + 1);
      check("oob_error", {31'h0, o_rsp_error}, 32'd1);
      check("oob_data",  o_rsp_read_data,      32'h0);
`else
      check("oob_cs",    cs_cnt - cs0,         32'd1);
      check("oob_cyc",   rc,                   n + 3);
      check("oob_error", {31'h0, o_rsp_error}, 32'd0);
      check("oob_data",  o_rsp_read_data,      32'hCAFE_0020);
`endif
      take_rsp();
      check("oob_txn", o_txn_count, 32'd4);

      // last mapped address
      cs0 = cs_cnt;
      send(1'b0, 12'h1FF, 32'h0, n);
      wait_rsp(rc);
      check("top_cs",    cs_cnt - cs0,         32'd1);
      check("top_cyc",   rc,                   n + 3);
      check("top_data",  o_rsp_read_data,      32'hCAFE_001F);
      check("top_error", {31'h0, o_rsp_error}, 32'd0);
      take_rsp();
      check("top_txn", o_txn_count, 32'd5);

      // reset in the middle of a read
      send(1'b0, 12'h040, 32'h0, n);
      check("mid_cs_issue", {31'h0, o_api_cs}, 32'd1);
      @(negedge clk);
      check("mid_wait_addr", {20'h0, o_api_address}, 32'h040);
      i_areset = 1'b1;
      #1;
      check("mid_rst_cs",    {31'h0, o_api_cs},      32'd0);
      check("mid_rst_addr",  {20'h0, o_api_address}, 32'h0);
      check("mid_rst_valid", {31'h0, o_rsp_valid},   32'd0);
      check("mid_rst_txn",   o_txn_count,            32'd0);
      @(negedge clk);
      i_areset = 1'b0;
      @(negedge clk);
      check("mid_rel_ready", {31'h0, o_cmd_ready}, 32'd1);
      stable = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (o_rsp_valid) stable = 1'b0;
      end
      check("mid_no_rsp", {31'h0, stable}, 32'd1);

      // counter wrap
      force dut.txn_count_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.txn_count_q;
      @(negedge clk);
      check("wrap_pre", o_txn_count, 32'hFFFF_FFFF);
      send(1'b1, 12'h050, 32'h0000_00A5, n);
      wait_rsp(rc);
      take_rsp();
      check("wrap_txn", o_txn_count, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
